// File: rtl/timer_periph.sv
// Memory-mapped timer / LED / 7-segment peripheral with the CPU external interrupt line.
// Define SYSTICK_EN to add a free-running read-only SYSTICK counter at offset 0x18.
module timer_periph #(
   parameter logic [31:0] BASE_ADDR = 32'h40000000,
   parameter int          LED_W     = 8,
   parameter int          DIGI_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic [LED_W-1:0]  led,
   output logic [DIGI_W-1:0] digi,
   output logic              irqout
);

   localparam logic [5:0] OFF_TH      = 6'h00;
   localparam logic [5:0] OFF_TL      = 6'h01;
   localparam logic [5:0] OFF_TCON    = 6'h02;
   localparam logic [5:0] OFF_LED     = 6'h03;
   localparam logic [5:0] OFF_DIGI    = 6'h05;
   localparam logic [5:0] OFF_SYSTICK = 6'h06;

   // Bus: no handshake. wr commits on the next rising edge, rd returns data
   // combinationally in the same cycle (0 when rd is low or the address misses).
   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic        sel;
   logic [5:0]  word;
   logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi;
   logic        overflow;
   logic        unused_addr_lsb;

   assign sel             = (addr[31:8] == BASE_ADDR[31:8]);
   assign word            = addr[7:2];
   assign unused_addr_lsb = ^addr[1:0];

   assign wr_th   = wr & sel & (word == OFF_TH);
   assign wr_tl   = wr & sel & (word == OFF_TL);
   assign wr_tcon = wr & sel & (word == OFF_TCON);
   assign wr_led  = wr & sel & (word == OFF_LED);
   assign wr_digi = wr & sel & (word == OFF_DIGI);

   assign overflow = tcon[0] & (tl == 32'hFFFFFFFF);

   // A bus write replaces the whole register, so a same-cycle timer update is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
         led  <= '0;
         digi <= '0;
      end else begin
         if (wr_th) th <= wdata;

         if (wr_tl)        tl <= wdata;
         else if (tcon[0]) tl <= overflow ? th : tl + 32'd1;

         if (wr_tcon)                  tcon    <= wdata[2:0];
         else if (overflow && tcon[1]) tcon[2] <= 1'b1;

         if (wr_led)  led  <= wdata[LED_W-1:0];
         if (wr_digi) digi <= wdata[DIGI_W-1:0];
      end
   end

   assign irqout = tcon[1] & tcon[2];

`ifdef SYSTICK_EN
   logic [31:0] systick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) systick <= '0;
      else       systick <= systick + 32'd1;
   end
`endif

   always_comb begin
      rdata = '0;
      if (rd && sel) begin
         case (word)
            OFF_TH:      rdata = th;
            OFF_TL:      rdata = tl;
            OFF_TCON:    rdata = {29'd0, tcon};
            OFF_LED:     rdata = {{(32-LED_W){1'b0}}, led};
            OFF_DIGI:    rdata = {{(32-DIGI_W){1'b0}}, digi};
`ifdef SYSTICK_EN
            OFF_SYSTICK: rdata = systick;
`endif
            default:     rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: directed scenarios plus randomized bus traffic,
// checked every cycle against a table-driven register model. Honors SYSTICK_EN.
module tb_timer_periph;

   localparam logic [31:0] BASE = 32'h40000000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [7:0]  led;
   logic [11:0] digi;
   logic        irqout;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   timer_periph dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .led(led), .digi(digi), .irqout(irqout)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- register model ----------------
   // Word-indexed register file; the mask says how many bits each word keeps (0 = unmapped).
   logic [31:0] regs [64];
   logic [31:0] mask [64];
   logic [31:0] m_systick;

   initial begin
      for (int i = 0; i < 64; i++) mask[i] = 32'h0;
      mask[0] = 32'hFFFFFFFF;   // TH
      mask[1] = 32'hFFFFFFFF;   // TL
      mask[2] = 32'h00000007;   // TCON
      mask[3] = 32'h000000FF;   // LED
      mask[5] = 32'h00000FFF;   // DIGI
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) regs[i] <= 32'h0;
         m_systick <= 32'h0;
      end else begin
         m_systick <= m_systick + 1;
         if (regs[2][0]) begin
            if (regs[1] == 32'hFFFFFFFF) begin
               regs[1] <= regs[0];
               if (regs[2][1]) regs[2] <= regs[2] | 32'h4;
            end else begin
               regs[1] <= regs[1] + 1;
            end
         end
         // Scheduled last so a bus write overrides the timer update.
         if (wr && addr[31:8] == BASE[31:8]) regs[addr[7:2]] <= wdata & mask[addr[7:2]];
      end
   end

   function automatic logic [31:0] model_rdata(input logic r, input logic [31:0] a);
      if (!r || a[31:8] != BASE[31:8]) return 32'h0;
`ifdef SYSTICK_EN
      if (a[7:2] == 6'd6) return m_systick;
`endif
      return regs[a[7:2]] & mask[a[7:2]];
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("rdata_model", rdata, model_rdata(rd, addr));
         check("led_model", {24'h0, led}, regs[3] & 32'hFF);
         check("digi_model", {20'h0, digi}, regs[5] & 32'hFFF);
         check("irq_model", {31'h0, irqout}, {31'h0, regs[2][1] & regs[2][2]});
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end 1 time unit after a rising edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
      rd = 1'b1; wr = 1'b0; addr = a;
      @(negedge clk);
      check(name, rdata, exp);
      @(posedge clk); #1;
      rd = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   int t_first;
   int words [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 16, 63};

   initial begin
      #1 reset = 1'b1;
      #1 check_en = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(1);

      // Reset state
      bus_read(BASE + 32'h00, 32'h0, "rst_th");
      bus_read(BASE + 32'h04, 32'h0, "rst_tl");
      bus_read(BASE + 32'h08, 32'h0, "rst_tcon");
      bus_read(BASE + 32'h0C, 32'h0, "rst_led");
      bus_read(BASE + 32'h14, 32'h0, "rst_digi");
      check("rst_irq", {31'h0, irqout}, 32'h0);

      // First reload and 256-cycle period
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h00, 32'hFFFFFF00);
      bus_write(BASE + 32'h04, 32'hFFFFFFFF);
      bus_write(BASE + 32'h08, 32'h3);
      idle(1);
      t_first = cyc;
      check("first_irq", {31'h0, irqout}, 32'h1);
      bus_read(BASE + 32'h04, 32'hFFFFFF00, "first_reload_tl");
      bus_read(BASE + 32'h08, 32'h7, "first_tcon");
      bus_write(BASE + 32'h08, 32'h1);
      bus_write(BASE + 32'h08, 32'h3);
      check("rearm_irq_low", {31'h0, irqout}, 32'h0);
      for (int i = 0; i < 400 && !irqout; i++) idle(1);
      check("period_256", cyc - t_first, 32'd256);

      // ISR acknowledge
      bus_read(BASE + 32'h08, 32'h7, "isr_tcon");
      bus_write(BASE + 32'h08, 32'h7 & 32'hFFF9);
      check("isr_irq_clear", {31'h0, irqout}, 32'h0);
      bus_read(BASE + 32'h04, 32'hFFFFFF02, "isr_tl_running");
      bus_write(BASE + 32'h08, 32'h3);
      idle(3);
      check("isr_irq_stays_low", {31'h0, irqout}, 32'h0);

      // TCON write during overflow wins
      bus_write(BASE + 32'h08, 32'h1);
      bus_write(BASE + 32'h04, 32'hFFFFFFFF);
      bus_write(BASE + 32'h08, 32'h3);
      check("wwin_irq", {31'h0, irqout}, 32'h0);
      bus_read(BASE + 32'h04, 32'hFFFFFF00, "wwin_tl_reload");
      bus_read(BASE + 32'h08, 32'h3, "wwin_tcon");

      // TL write during overflow wins, status still set
      bus_write(BASE + 32'h04, 32'hFFFFFFFF);
      bus_write(BASE + 32'h04, 32'h5);
      check("tlw_irq", {31'h0, irqout}, 32'h1);
      bus_read(BASE + 32'h04, 32'h5 + 32'h0, "tlw_tl");
      bus_read(BASE + 32'h08, 32'h7, "tlw_tcon");
      bus_write(BASE + 32'h08, 32'h0);

      // LED / DIGI and decode misses
      bus_write(BASE + 32'h0C, 32'h1A5);
      bus_write(BASE + 32'h14, 32'h8F9);
      check("led_val", {24'h0, led}, 32'hA5);
      check("digi_val", {20'h0, digi}, 32'h8F9);
      bus_write(BASE + 32'h100, 32'hDEADBEEF);
      bus_write(BASE + 32'h10, 32'h55);
      bus_read(BASE + 32'h100, 32'h0, "miss_base");
      bus_read(BASE + 32'h10, 32'h0, "miss_off10");
      bus_read(BASE + 32'h00, 32'hFFFFFF00, "th_untouched");
      check("led_untouched", {24'h0, led}, 32'hA5);
      rd = 1'b0; addr = BASE;
      @(negedge clk);
      check("rd_low_zero", rdata, 32'h0);
      idle(1);
      rd = 1'b1; wr = 1'b1; addr = BASE + 32'h0C; wdata = 32'h3C;
      @(negedge clk);
      check("rdwr_pre_edge", rdata, 32'hA5);
      idle(1);
      rd = 1'b0; wr = 1'b0;
      check("rdwr_post_edge", {24'h0, led}, 32'h3C);

      // Asynchronous reset mid-count
      bus_write(BASE + 32'h08, 32'h0);
      bus_write(BASE + 32'h04, 32'hFFFFFF80);
      bus_write(BASE + 32'h08, 32'h3);
      idle(4);
      rd = 1'b1; addr = BASE + 32'h04;
      #2 reset = 1'b1;
      #1;
      check("async_rst_tl", rdata, 32'h0);
      check("async_rst_irq", {31'h0, irqout}, 32'h0);
      check("async_rst_led", {24'h0, led}, 32'h0);
      idle(2);
      reset = 1'b0;
      rd = 1'b0;
      idle(5);
`ifdef SYSTICK_EN
      bus_read(BASE + 32'h18, 32'h5, "systick_5");
      bus_write(BASE + 32'h18, 32'h1234);
      bus_read(BASE + 32'h18, 32'h7, "systick_ro");
`else
      bus_read(BASE + 32'h18, 32'h0, "off18_unmapped");
`endif
      bus_read(BASE + 32'h04, 32'h0, "post_rst_tl_hold");
      bus_read(BASE + 32'h08, 32'h0, "post_rst_tcon");

      // Randomized traffic checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         logic [5:0]  w;
         logic [23:0] b;
         w = 6'(words[$urandom_range(0, 9)]);
         b = ($urandom_range(0, 7) == 0) ? 24'h400001 : 24'h400000;
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 3) == 0);
         addr = {b, w, 2'($urandom_range(0, 3))};
         case (w)
            6'd0: wdata = $urandom_range(0, 1) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            6'd1: wdata = $urandom_range(0, 1) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            6'd2: wdata = {$urandom_range(0, 1) ? 29'h1FFFFFFF : 29'h0, 3'($urandom_range(0, 7))};
            default: wdata = $urandom;
         endcase
         if (i == 1500) reset = 1'b1;
         if (i == 1503) reset = 1'b0;
         idle(1);
      end
      rd = 1'b0; wr = 1'b0;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/timer_periph.md
Name: timer_periph

Overview:
Memory-mapped peripheral responder on the CPU data bus at base 0x40000000; the target of the boot/ISR program's sw/lw traffic.
- Holds a reloadable 32-bit timer (TH/TL/TCON), an LED register and a 7-segment digit register.
- Drives the CPU external interrupt line.
- Word-addressed, single-cycle bus: writes commit on clk edge, reads are combinational.

Parameters:
BASE_ADDR, 32'h40000000, peripheral base; decode matches addr[31:8] == BASE_ADDR[31:8]
LED_W, 8, LED register width
DIGI_W, 12, digit register width (anode select [11:8], segments [7:0])

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rd  input  1  bus read strobe
wr  input  1  bus write strobe
addr  input  32  byte address; addr[1:0] ignored
wdata  input  32  write data
rdata  output  32  read data, combinational
led  output  LED_W  LED register
digi  output  DIGI_W  digit register
irqout  output  1  interrupt request to CPU

Behaviour:
- Register map (offset = addr[7:0]):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bits [2:0], R/W, upper bits read 0. bit0 = enable, bit1 = irq enable, bit2 = irq status.
  - 0x0C LED: R/W, zero-extended on read.
  - 0x14 DIGI: R/W, zero-extended on read.
- Unmapped offsets or addr[31:8] mismatch: writes ignored, rdata = 0.
- rd low: rdata = 0.
- Reset (async, immediate): TH = 0, TL = 0, TCON = 0, led = 0, digi = 0, irqout = 0.
- Timer, each rising clk edge with TCON[0] = 1:
  - TL != 32'hFFFFFFFF: TL <= TL + 1.
  - TL == 32'hFFFFFFFF: TL <= TH, and if TCON[1] = 1 then TCON[2] <= 1.
- TCON[0] = 0: TL holds; no status set.
- Period after reload is (2^32 - TH) cycles. TH = 0xFFFFFF00 gives 256 cycles.
- TH = 0xFFFFFFFF: overflow every cycle; status set each cycle.
- irqout = TCON[1] & TCON[2], combinational from registers; stays high until software clears bit1 or bit2.
- Simultaneous write and timer update to the same register in one cycle: bus write wins for the whole register.
  - wr to TL during overflow: TL = wdata, no reload.
  - wr to TCON during overflow: TCON = wdata[2:0], overflow status set is dropped.
  - Overflow with wr to TL still sets status (status lives in TCON).
- Software may set TCON[2] directly by write.
- rd and wr in the same cycle: rdata shows pre-edge value.
- Reset asserted mid-count: counter and all state clear immediately; counting resumes only after software sets TCON[0].

Optional Feature:
SYSTICK_EN
- Defined: adds read-only 32-bit SYSTICK at offset 0x18. Reset 0, increments every clk unconditionally, wraps 0xFFFFFFFF -> 0. Writes to 0x18 ignored.
- Undefined: no counter logic; offset 0x18 reads 0 like any unmapped offset.

Test Plan:
- Reset, then read 0x40000000/04/08/0C/14 -> all 0; irqout = 0.
- Write TCON = 0, TH = 0xFFFFFF00, TL = 0xFFFFFFFF, TCON = 3 -> first enabled edge gives TL = 0xFFFFFF00, TCON reads 7, irqout = 1. Clear TCON to 1, re-arm TCON = 3 -> next irqout rise exactly 256 cycles after the first reload.
- ISR sequence: read TCON = 7, write 7 & 0xFFF9 = 1 -> irqout = 0 next cycle, counter keeps running. Write TCON = 3 -> irqout stays 0 until next overflow.
- Write TCON = 3 in the same cycle TL overflows -> TCON reads 3, TL = TH, irqout = 0 (write wins).
- Write LED = 0x1A5, DIGI = 0x8F9 -> led = 0xA5, digi = 0x8F9. Write to 0x40000100 and offset 0x10 -> no register change, reads 0.
- Assert reset mid-count with TL = 0xFFFFFF80 -> TL = 0, TCON = 0, irqout = 0 immediately (before next edge). With SYSTICK_EN, 0x18 reads 5 after 5 edges post-reset.
